// File: rtl/decoder_scan_pkg.sv
// Shared constants and helpers for the 3x8 decoder scan controller.
// The optional DECODER_SCAN_DIR_EN build uses the downward address constants.
package decoder_scan_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Address range for an upward scan
    localparam logic [2:0] ADDR_FIRST_UP   = 3'd0;
    localparam logic [2:0] ADDR_LAST_UP    = 3'd7;

    // Address range for a downward scan
    localparam logic [2:0] ADDR_FIRST_DOWN = 3'd7;
    localparam logic [2:0] ADDR_LAST_DOWN  = 3'd0;

    // First address of a pass for the given direction (1 = downward)
    function automatic logic [2:0] scan_first(input logic dir_down);
        return dir_down ? ADDR_FIRST_DOWN : ADDR_FIRST_UP;
    endfunction

    // Last address of a pass for the given direction (1 = downward)
    function automatic logic [2:0] scan_last(input logic dir_down);
        return dir_down ? ADDR_LAST_DOWN : ADDR_LAST_UP;
    endfunction

    // Following address, wrapping modulo 8 through the 3-bit width
    function automatic logic [2:0] scan_next(input logic [2:0] addr, input logic dir_down);
        return dir_down ? (addr - 3'd1) : (addr + 3'd1);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Per-address dwell down-counter: loads a value, counts down to zero and
// holds there; o_zero marks the final cycle of the current dwell period.
module dwell_counter #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [DWELL_W-1:0] r_cnt;

    // Load has priority over decrement; the count never wraps below zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller driving a 3x8 decoder: steps the select code through all
// eight addresses, holding each for dwell+1 cycles, in one pass or continuously.
// Optional macro DECODER_SCAN_DIR_EN adds a dir input for downward scans.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DECODER_SCAN_DIR_EN
    input  logic               dir,
`endif
    output logic [2:0]         d,
    output logic               en,
    output logic               busy,
    output logic               done
);

    logic [1:0]         r_state;
    logic [2:0]         r_addr;
    logic               r_en;
    logic               r_busy;
    logic               r_done;
    logic               r_single;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_dir;

    logic               w_dir_in;
    logic               w_start_ok;
    logic               w_zero;
    logic               w_last;
    logic               w_cnt_load;
    logic [DWELL_W-1:0] w_cnt_val;
    logic               w_cnt_dec;

`ifdef DECODER_SCAN_DIR_EN
    assign w_dir_in = dir;
`else
    assign w_dir_in = 1'b0;
`endif

    // stop wins over start in IDLE; start is not looked at in any other state
    assign w_start_ok = (r_state == IDLE) && start && !stop;
    assign w_last     = (r_addr == scan_last(r_dir));
    assign w_cnt_dec  = (r_state == SCAN) && !stop;

    // Counter control: arm with the new dwell at start, re-arm at each address
    // step, and clear when the scan ends so IDLE always sees a zero count
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = dwell;
                end
            end
            SCAN: begin
                if (stop) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = '0;
                end else if (w_zero) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = (w_last && r_single) ? '0 : r_dwell;
                end
            end
            default: begin
                w_cnt_load = 1'b0;
            end
        endcase
    end

    dwell_counter #(
        .DWELL_W    (DWELL_W)
    ) u_dwell_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_zero)
    );

    // FSM, address register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_addr   <= 3'd0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_single <= 1'b0;
            r_dwell  <= '0;
            r_dir    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state  <= SCAN;
                        r_addr   <= scan_first(w_dir_in);
                        r_en     <= 1'b1;
                        r_busy   <= 1'b1;
                        r_single <= single;
                        r_dwell  <= dwell;
                        r_dir    <= w_dir_in;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_addr  <= 3'd0;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_zero) begin
                        if (w_last && r_single) begin
                            r_state <= DONE;
                            r_addr  <= 3'd0;
                            r_en    <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_last) begin
                            // continuous mode: back to the first address, no gap
                            r_addr <= scan_first(r_dir);
                        end else begin
                            r_addr <= scan_next(r_addr, r_dir);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_addr  <= 3'd0;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign d    = r_addr;
    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl: a table of single-pass scans,
// hand-written corner sequences and a randomized run, all compared every cycle
// against an elapsed-cycle reference model.
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       single;
    logic [3:0] dwell;
    logic       dir_v;
    logic [2:0] d;
    logic       en;
    logic       busy;
    logic       done;

    int total;
    int bad;

    decoder_scan_ctrl #(
        .DWELL_W (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .single (single),
        .dwell  (dwell),
`ifdef DECODER_SCAN_DIR_EN
        .dir    (dir_v),
`endif
        .d      (d),
        .en     (en),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase (0 idle, 1 scanning, 2 done) plus the number of
    // cycles elapsed since the pass began; the address is derived arithmetically.
    int m_ph;
    int m_k;
    int m_dw;
    bit m_single;
    bit m_dir;

    function automatic void model_reset();
        m_ph = 0; m_k = 0; m_dw = 1; m_single = 0; m_dir = 0;
    endfunction

    function automatic void model_step();
        case (m_ph)
            0: if (start && !stop) begin
                m_ph = 1; m_k = 0; m_dw = int'(dwell) + 1;
                m_single = single; m_dir = dir_v;
            end
            1: if (stop) begin
                m_ph = 0;
            end else begin
                m_k++;
                if (m_k == 8 * m_dw) begin
                    if (m_single) m_ph = 2;
                    else          m_k = 0;
                end
            end
            default: m_ph = 0;
        endcase
    endfunction

    task automatic check(input string name);
        logic [2:0] ed;
        logic       ee, eo, eb;
        int         idx;
        idx = m_k / m_dw;
        ed  = (m_ph == 1) ? (m_dir ? 3'(7 - idx) : 3'(idx)) : 3'd0;
        ee  = (m_ph == 1);
        eo  = (m_ph == 2);
        eb  = (m_ph != 0);
        total++;
        if (d !== ed || en !== ee || done !== eo || busy !== eb) begin
            bad++;
            $display("FAIL %s @%0t: got d=%0d en=%0b done=%0b busy=%0b, want d=%0d en=%0b done=%0b busy=%0b",
                     name, $time, d, en, done, busy, ed, ee, eo, eb);
        end
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        model_step();
        #1;
        check(name);
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Pulse start, then run until busy falls, counting enable cycles and done pulses
    task automatic run_scan(input string name, output int en_cnt, output int done_cnt, output int n);
        start = 1'b1;
        tick(name);
        start = 1'b0;
        en_cnt = 0; done_cnt = 0; n = 0;
        while (busy && n < 400) begin
            if (en)   en_cnt++;
            if (done) done_cnt++;
            tick(name);
            n++;
        end
    endtask

    typedef struct {
        bit single;
        int dwell;
        int exp_en;
        int exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int en_cnt, done_cnt, n, done_seen;
        bit wrapped;
        logic [2:0] prev_d;

        total = 0; bad = 0;
        vecs[0] = '{single: 1'b1, dwell: 0,  exp_en: 8,   exp_done: 1};
        vecs[1] = '{single: 1'b1, dwell: 2,  exp_en: 24,  exp_done: 1};
        vecs[2] = '{single: 1'b1, dwell: 1,  exp_en: 16,  exp_done: 1};
        vecs[3] = '{single: 1'b1, dwell: 15, exp_en: 128, exp_done: 1};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; single = 1'b0; dwell = 4'd0; dir_v = 1'b0;
        model_reset();
        #3;
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick("post_reset_idle");
        tick("post_reset_idle");

        // Table-driven single-pass scans
        for (int i = 0; i < 4; i++) begin
            single = vecs[i].single;
            dwell  = 4'(vecs[i].dwell);
            run_scan("table_scan", en_cnt, done_cnt, n);
            expect_int("table_bound",  int'(n < 400), 1);
            expect_int("table_en_cyc", en_cnt,   vecs[i].exp_en);
            expect_int("table_done",   done_cnt, vecs[i].exp_done);
            $display("vector %0d: dwell=%0d en_cycles=%0d done_pulses=%0d", i, vecs[i].dwell, en_cnt, done_cnt);
            tick("table_idle");
        end

        // start and stop together in IDLE: nothing happens
        start = 1'b1; stop = 1'b1;
        tick("start_stop_idle");
        expect_int("start_stop_busy", int'(busy), 0);
        start = 1'b0; stop = 1'b0;
        tick("start_stop_idle");
        $display("sequence: start+stop in idle, busy=%0b", busy);

        // Continuous scan: wrap 7->0, ignored start/dwell/single changes, stop at d=3
        single = 1'b0; dwell = 4'd0;
        start = 1'b1;
        tick("cont_start");
        start = 1'b0;
        wrapped = 1'b0; done_seen = 0; n = 0;
        prev_d = d;
        while (!(wrapped && en && d == 3'd3) && n < 60) begin
            if (n == 4) begin
                start = 1'b1; dwell = 4'd5; single = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick("cont_scan");
            if (done) done_seen++;
            if (prev_d == 3'd7 && d == 3'd0 && en) wrapped = 1'b1;
            prev_d = d;
            n++;
        end
        start = 1'b0;
        expect_int("cont_reach_d3", int'(n < 60), 1);
        stop = 1'b1;
        tick("cont_stop");
        stop = 1'b0;
        expect_int("stop_en_d", int'({en, d}), 0);
        if (done) done_seen++;
        tick("cont_after_stop");
        if (done) done_seen++;
        expect_int("cont_no_done", done_seen, 0);
        $display("sequence: continuous scan wrapped=%0b stopped after %0d cycles", wrapped, n);

        // Asynchronous reset at d=5
        single = 1'b1; dwell = 4'd1;
        start = 1'b1;
        tick("areset_start");
        start = 1'b0;
        n = 0;
        while (!(en && d == 3'd5) && n < 60) begin
            tick("areset_wait");
            n++;
        end
        expect_int("areset_reach_d5", int'(n < 60), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("areset_immediate");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("areset_idle_hold");
        $display("sequence: async reset at d=5, en=%0b busy=%0b", en, busy);

`ifdef DECODER_SCAN_DIR_EN
        // Downward single pass
        dir_v = 1'b1; single = 1'b1; dwell = 4'd0;
        run_scan("dir_down", en_cnt, done_cnt, n);
        expect_int("dir_en_cyc", en_cnt, 8);
        expect_int("dir_done",   done_cnt, 1);
        $display("sequence: downward scan en_cycles=%0d done_pulses=%0d", en_cnt, done_cnt);
        dir_v = 1'b0;
        tick("dir_idle");
`endif

        // Randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom % 8) == 0;
            stop   = ($urandom % 40) == 0;
            single = $urandom % 2;
            dwell  = 4'($urandom % 4);
`ifdef DECODER_SCAN_DIR_EN
            dir_v  = $urandom % 2;
`endif
            tick("random");
        end
        start = 1'b0; stop = 1'b0;
        $display("sequence: 600 random cycles done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
